// File: rtl/serial_mag_cmp.sv
// Bit-serial magnitude comparator: scans two WIDTH-bit operands MSB first,
// one bit per clock, stopping at the first differing bit. Unsigned or two's-complement.
module serial_mag_cmp #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             gt,
   output logic             eq,
   output logic             lt
);

   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CMP  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state, nstate;
   logic [WIDTH-1:0] ra, rb;
   logic             rsm;
   logic [IW-1:0]    idx;

   logic abit, bbit, differ, decide, sign_pos, accept;

   assign abit     = ra[idx];
   assign bbit     = rb[idx];
   assign differ   = abit ^ bbit;
   assign decide   = differ || (idx == '0);
   // In signed mode the sign bit carries negative weight, so its sense flips.
   assign sign_pos = rsm && (idx == IW'(WIDTH-1));
   assign accept   = start && ((state == S_IDLE) || (state == S_DONE));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= nstate;
   end

   always_comb begin
      nstate = S_IDLE;
      case (state)
         S_IDLE:  nstate = start  ? S_CMP  : S_IDLE;
         S_CMP:   nstate = decide ? S_DONE : S_CMP;
         S_DONE:  nstate = start  ? S_CMP  : S_IDLE;
         default: nstate = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state == S_CMP);
      done = (state == S_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ra  <= '0;
         rb  <= '0;
         rsm <= 1'b0;
         idx <= '0;
         gt  <= 1'b0;
         eq  <= 1'b0;
         lt  <= 1'b0;
      end else if (accept) begin
         ra  <= a;
         rb  <= b;
         rsm <= signed_mode;
         idx <= IW'(WIDTH-1);
      end else if (state == S_CMP) begin
         if (decide) begin
            gt <= differ & (sign_pos ? bbit : abit);
            lt <= differ & (sign_pos ? abit : bbit);
            eq <= ~differ;
         end else begin
            idx <= idx - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_serial_mag_cmp.sv
// Directed bench for serial_mag_cmp (WIDTH=8): latency, result and handshake
// checks against hand-computed expectations.
module tb_serial_mag_cmp;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       signed_mode = 1'b0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic       busy, done, gt, eq, lt;

   int total = 0;
   int bad   = 0;

   serial_mag_cmp #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
      .a(a), .b(b), .busy(busy), .done(done), .gt(gt), .eq(eq), .lt(lt)
   );

   always #5 clk = ~clk;

   // Drive one start, accepted on the following rising edge (cycle 0).
   task automatic launch(input logic [7:0] va, input logic [7:0] vb, input logic sm);
      @(negedge clk);
      a = va; b = vb; signed_mode = sm; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Counts cycles after the accept edge until done is seen (bounded).
   task automatic wait_done(output int cyc, output int bc);
      cyc = 0; bc = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (busy) bc++;
      end while (!done && cyc < 40);
   endtask

   task automatic test_reset;
      @(negedge clk);
      total++;
      if ({busy, done, gt, eq, lt} !== 5'b0) begin
         bad++; $display("FAIL reset_hold got=%b exp=00000", {busy, done, gt, eq, lt});
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({busy, done, gt, eq, lt} !== 5'b0) begin
         bad++; $display("FAIL idle_after_reset got=%b exp=00000", {busy, done, gt, eq, lt});
      end
   endtask

   task automatic test_unsigned;
      int cyc, bc;
      launch(8'hA0, 8'h20, 1'b0);
      wait_done(cyc, bc);
      total++;
      if (cyc !== 2) begin bad++; $display("FAIL uns_latency got=%0d exp=2", cyc); end
      total++;
      if (bc !== 1) begin bad++; $display("FAIL uns_busy got=%0d exp=1", bc); end
      total++;
      if ({gt, eq, lt} !== 3'b100) begin
         bad++; $display("FAIL uns_result got=%b exp=100", {gt, eq, lt});
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0) begin bad++; $display("FAIL done_one_cycle got=%b exp=0", done); end
   endtask

   task automatic test_signed;
      int cyc, bc;
      launch(8'hA0, 8'h20, 1'b1);
      wait_done(cyc, bc);
      total++;
      if (cyc !== 2) begin bad++; $display("FAIL sgn_latency got=%0d exp=2", cyc); end
      total++;
      if ({gt, eq, lt} !== 3'b001) begin
         bad++; $display("FAIL sgn_result got=%b exp=001", {gt, eq, lt});
      end
   endtask

   task automatic test_sign_boundary;
      int cyc, bc;
      launch(8'h7F, 8'h80, 1'b1);
      wait_done(cyc, bc);
      total++;
      if ({cyc, gt, eq, lt} !== {32'd2, 3'b100}) begin
         bad++; $display("FAIL sgn_7f_80 got=%0d/%b exp=2/100", cyc, {gt, eq, lt});
      end
      launch(8'h7F, 8'h80, 1'b0);
      wait_done(cyc, bc);
      total++;
      if ({cyc, gt, eq, lt} !== {32'd2, 3'b001}) begin
         bad++; $display("FAIL uns_7f_80 got=%0d/%b exp=2/001", cyc, {gt, eq, lt});
      end
      // Both negative: decision falls below the sign bit, normal sense (k=3).
      launch(8'hF0, 8'hE0, 1'b1);
      wait_done(cyc, bc);
      total++;
      if ({cyc, gt, eq, lt} !== {32'd5, 3'b100}) begin
         bad++; $display("FAIL sgn_f0_e0 got=%0d/%b exp=5/100", cyc, {gt, eq, lt});
      end
   endtask

   task automatic test_back_to_back;
      int cyc, bc;
      launch(8'h5C, 8'h5C, 1'b0);
      wait_done(cyc, bc);
      total++;
      if (cyc !== 9) begin bad++; $display("FAIL eq_latency got=%0d exp=9", cyc); end
      total++;
      if (bc !== 8) begin bad++; $display("FAIL eq_busy got=%0d exp=8", bc); end
      total++;
      if ({gt, eq, lt} !== 3'b010) begin
         bad++; $display("FAIL eq_result got=%b exp=010", {gt, eq, lt});
      end
      // Still in DONE: hold start high so the next edge re-accepts.
      a = 8'h01; b = 8'h02; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b exp=1", busy); end
      wait_done(cyc, bc);
      total++;
      if (cyc !== 8) begin bad++; $display("FAIL b2b_latency got=%0d exp=8", cyc); end
      total++;
      if ({gt, eq, lt} !== 3'b001) begin
         bad++; $display("FAIL b2b_result got=%b exp=001", {gt, eq, lt});
      end
   endtask

   task automatic test_ignored_start;
      int nd, first;
      nd = 0; first = 0;
      launch(8'h10, 8'h20, 1'b0);
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         if (done) begin
            nd++;
            if (first == 0) first = i;
         end
         if (i == 1) begin start = 1'b1; a = 8'hFF; signed_mode = 1'b1; end
         if (i == 2) start = 1'b0;
      end
      total++;
      if (nd !== 1) begin bad++; $display("FAIL ign_done_count got=%0d exp=1", nd); end
      total++;
      if (first !== 4) begin bad++; $display("FAIL ign_latency got=%0d exp=4", first); end
      total++;
      if ({gt, eq, lt} !== 3'b001) begin
         bad++; $display("FAIL ign_result got=%b exp=001", {gt, eq, lt});
      end
   endtask

   task automatic test_reset_mid;
      int nd, cyc, bc;
      nd = 0;
      launch(8'h01, 8'h00, 1'b0);
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      total++;
      if ({busy, done, gt, eq, lt} !== 5'b0) begin
         bad++; $display("FAIL async_reset got=%b exp=00000", {busy, done, gt, eq, lt});
      end
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (i == 1) rst = 1'b0;
         if (done) nd++;
      end
      total++;
      if (nd !== 0) begin bad++; $display("FAIL abort_done got=%0d exp=0", nd); end
      total++;
      if ({gt, eq, lt} !== 3'b000) begin
         bad++; $display("FAIL abort_result got=%b exp=000", {gt, eq, lt});
      end
      launch(8'h03, 8'h03, 1'b0);
      wait_done(cyc, bc);
      total++;
      if ({cyc, gt, eq, lt} !== {32'd9, 3'b010}) begin
         bad++; $display("FAIL post_reset_eq got=%0d/%b exp=9/010", cyc, {gt, eq, lt});
      end
   endtask

   initial begin
      test_reset;
      test_unsigned;
      test_signed;
      test_sign_boundary;
      test_back_to_back;
      test_ignored_start;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serial_mag_cmp.md
Name: serial_mag_cmp

Overview:
- Parametrised, sequential successor to the 2-bit combinational comparator (inputs a/b vs c/d, outputs f1/f2/f3).
- Compares two WIDTH-bit operands bit-serially, MSB first, one bit per clock; stops early at the first differing bit.
- Supports unsigned and two's-complement signed modes, with a start/busy/done handshake.
- Used as a reusable compare unit in lab datapaths where a wide combinational comparator is not wanted.

Parameters:
- WIDTH, 8, operand width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a compare; sampled on rising clk.
- signed_mode  input  1  0 = unsigned, 1 = two's-complement; captured with the operands.
- a  input  WIDTH  operand A; captured when start is accepted.
- b  input  WIDTH  operand B; captured when start is accepted.
- busy  output  1  high while a compare is in progress.
- done  output  1  one-cycle pulse when results update.
- gt  output  1  A > B (registered).
- eq  output  1  A == B (registered).
- lt  output  1  A < B (registered).

Behaviour:
- Reset (async, rst=1): state=IDLE immediately; busy=0, done=0, gt=0, eq=0, lt=0; internal operand registers and bit index cleared.
- Reset asserted mid-compare aborts it immediately. No done pulse is produced and the aborted result is never reported.
- States: IDLE, COMPARE, DONE. The state register is 2 bits; unused encodings go to IDLE.
- start is accepted only when busy=0, i.e. in IDLE or DONE.
  - On acceptance: latch a, b, signed_mode; set idx=WIDTH-1; go to COMPARE.
  - start while busy=1 is ignored; a, b and signed_mode changes are ignored while busy=1.
- COMPARE: busy=1. Each cycle examines bit idx of the latched operands.
  - Bits equal and idx>0: idx decrements; stay in COMPARE.
  - Bits differ, unsigned (or signed with idx<WIDTH-1): a bit 1 gives gt=1; b bit 1 gives lt=1.
  - Bits differ, signed_mode=1 and idx=WIDTH-1 (sign bit): the sense inverts. a bit 1 (A negative) gives lt=1; b bit 1 gives gt=1.
  - Bits equal and idx=0: eq=1.
  - When a decision is made: gt/eq/lt are written one-hot in the same edge, and the block moves to DONE.
- DONE: busy=0, done=1 for exactly one cycle.
  - Next state is COMPARE if start=1 (back-to-back accept), otherwise IDLE.
- gt/eq/lt hold their last one-hot value until the next decision edge. They are not cleared on start, and remain valid through IDLE.
- Latency: let k be the position of the first differing bit counted from the MSB (MSB = 0).
  - done is high in cycle k+2 after the cycle in which start is sampled.
  - Equal operands: done is high in cycle WIDTH+1.
  - Cycles from start accept to next accept in back-to-back mode: k+2.
- busy rises in the cycle after start is sampled and falls when DONE is entered.
- gt, eq and lt are never simultaneously high. After reset and before the first done, all three are 0.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> busy, done, gt, eq, lt all drop to 0 immediately, without waiting for a clk edge.
- Unsigned early exit, WIDTH=8: a=8'hA0, b=8'h20, signed_mode=0 -> MSB differs (k=0); done pulses in cycle 2 with gt=1, eq=0, lt=0; busy was high for exactly 1 cycle.
- Signed sign bit: same a=8'hA0, b=8'h20, signed_mode=1 -> lt=1 (-96 < 32), done in cycle 2.
- Equal full scan: a=b=8'h5C -> eq=1, done in cycle 9, busy high for 8 cycles. Then start held high through DONE with a=8'h01, b=8'h02 -> back-to-back accept; lt=1 after the LSB-region difference (k=6), done 8 cycles after the re-accept.
- Ignored start and operand change: while busy, pulse start and change a to 8'hFF -> result reflects the originally latched operands; exactly one done pulse occurs.
- Reset mid-compare: a=8'h01, b=8'h00 (k=7); assert rst at cycle 4 -> no done pulse and outputs 0. After release, a new start with a=8'h03, b=8'h03 -> eq=1 in cycle 9.
